intfrac_join: RTL
=================

INTFRAC_JOIN -- requirements
Module: intfrac_join

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter BIAS, default 127: IEEE-754 single exponent bias.
REQ-003 Parameter ACC_W, default 32: accumulator width (8 integer + 24 fraction bits).
REQ-004 Port clk  input  1: rising-edge clock.
REQ-005 Port rst_n  input  1: asynchronous active-low reset.
REQ-006 Port start  input  1: request pulse, sampled only in IDLE.
REQ-007 Port int_in  input  8: unsigned integer part, 0..255.
REQ-008 Port frac_in  input  32: IEEE-754 single fractional part, nominally in [0,1).
REQ-009 Port fp_out  output  32: IEEE-754 single result int_in + frac_in, held until the next done.
REQ-010 Port done  output  1: one-cycle pulse when fp_out is updated.
REQ-011 Port busy  output  1: high in every state except IDLE.
REQ-012 Port err  output  1: valid with done; high when frac_in exponent field >= 127.

Function
REQ-013 States SHALL be IDLE, NORM and DONE; reset enters IDLE.
REQ-014 IDLE with start=1 SHALL latch int_in and frac_in, form acc, and go to NORM at that edge; start=0 stays in IDLE.
REQ-015 Fraction alignment SHALL be: e = frac_in[30:23]; frac_fix[23:0] = {1,frac_in[22:0]} >> (126-e) for 103 <= e <= 126; frac_fix = 0 for e < 103 (includes zero and denormals, truncated).
REQ-016 For e >= 127 (including Inf/NaN), frac_fix SHALL be 0 and err SHALL be latched as 1; otherwise err is latched as 0.
REQ-017 frac_in[31] SHALL be ignored; the fp_out sign SHALL always be 0.
REQ-018 acc SHALL be {int_in, frac_fix}, and the shift count s SHALL be cleared at load.
REQ-019 In NORM with acc != 0 and acc[31] = 0: acc <<= 1 and s += 1 per clock.
REQ-020 In NORM with acc[31] = 1: fp_out = {0, BIAS+7-s, acc[30:8]}, with truncation and no rounding; done = 1; go to DONE.
REQ-021 In NORM with acc == 0: fp_out = 0x00000000; done = 1; go to DONE.
REQ-022 DONE SHALL return to IDLE on the next edge and drop done, so done is exactly one cycle wide.
REQ-023 Latency from the start-sampling edge to the edge raising done SHALL be s+1 clocks, with s in 0..31; a zero result has latency 1.
REQ-024 start while busy = 1 SHALL be ignored, with no queuing.
REQ-025 start asserted in the cycle that DONE returns to IDLE SHALL be sampled at the next edge, after IDLE is reached.
REQ-026 Input changes after the sampling edge SHALL NOT affect the result.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, acc = 0, s = 0, fp_out = 0, done = 0, busy = 0, err = 0.
REQ-028 Reset mid-operation SHALL abort the operation; no done pulse follows, and the next start after release is processed normally.

Structure
REQ-029 Package intfrac_pkg SHALL hold BIAS, ACC_W, the state enumeration and the e-range limits 103/126.
REQ-030 Combinational sub-module frac_align (frac_in -> frac_fix, err) SHALL implement REQ-015 and REQ-016.
REQ-031 The normalizer shift register, counter and FSM SHALL reside in intfrac_join.

Verification
REQ-032 int_in = 10, frac_in = 0x3E99999A (0.3): fp_out = 0x4124CCCC, err = 0, done 5 clocks after the sampling edge (s = 4).
REQ-033 int_in = 0, frac_in = 0x3F000000: fp_out = 0x3F000000 (s = 8); int_in = 1, frac_in = 0: fp_out = 0x3F800000 (s = 7).
REQ-034 int_in = 0, frac_in = 0x00000000: fp_out = 0x00000000, done one clock after the sampling edge.
REQ-035 int_in = 255, frac_in = 0x3F800000: fp_out = 0x437F0000, err = 1, s = 0.
REQ-036 start pulsed in NORM is ignored; rst_n low mid-NORM causes all outputs to go 0 with no done; a subsequent start with int_in = 2, frac_in = 0 gives fp_out = 0x40000000.

Source files
------------

// File: rtl/intfrac_pkg.sv
// intfrac_pkg: shared constants and FSM state type for the integer+fraction
// to IEEE-754 single-precision joiner.
//   BIAS   - single-precision exponent bias
//   ACC_W  - normaliser accumulator width (8 integer + 24 fraction bits)
//   FRAC_W - width of the fixed-point fraction produced by frac_align
//   E_MIN/E_MAX - exponent-field range that contributes fraction bits
package intfrac_pkg;

  localparam int unsigned BIAS   = 127;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned FRAC_W = 24;
  localparam int unsigned E_MIN  = 103;
  localparam int unsigned E_MAX  = 126;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/intfrac_join_frac_align.sv
// frac_align: converts an IEEE-754 single value in [0,1) into a 24-bit
// fixed-point fraction (weight of bit 23 is 2^-1). Sign is ignored.
//   frac_in  [31:0] in  - IEEE-754 single fractional operand
//   frac_fix [23:0] out - truncated fixed-point fraction
//   err           out - exponent field >= 127 (value >= 1.0, Inf or NaN)
module frac_align
  import intfrac_pkg::*;
(
  input  logic [31:0]       frac_in,
  output logic [FRAC_W-1:0] frac_fix,
  output logic              err
);

  logic [7:0] e;

  assign e = frac_in[30:23];

  always_comb begin
    frac_fix = '0;
    err      = 1'b0;
    if (e > 8'(E_MAX)) begin
      err = 1'b1;
    end else if (e >= 8'(E_MIN)) begin
      // e = 126 means 0.5 <= x < 1, so the hidden one lands on bit 23.
      frac_fix = {1'b1, frac_in[22:0]} >> (8'(E_MAX) - e);
    end
  end

endmodule

// File: rtl/intfrac_join.sv
// intfrac_join: forms int_in + frac_in as an IEEE-754 single by loading a
// fixed-point accumulator and shifting it left until the MSB is set.
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - request pulse, sampled only in IDLE
//   int_in  [7:0] - unsigned integer part
//   frac_in [31:0]- IEEE-754 single fraction in [0,1)
//   fp_out  [31:0]- result, held until the next done
//   done          - one-cycle pulse when fp_out updates
//   busy          - high outside IDLE
//   err           - frac_in exponent field >= 127, valid with done
module intfrac_join #(
  parameter int unsigned BIAS  = intfrac_pkg::BIAS,
  parameter int unsigned ACC_W = intfrac_pkg::ACC_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  int_in,
  input  logic [31:0] frac_in,
  output logic [31:0] fp_out,
  output logic        done,
  output logic        busy,
  output logic        err
);

  import intfrac_pkg::*;

  localparam int unsigned S_W = $clog2(ACC_W);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [31:0]        fp_q, fp_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [FRAC_W-1:0]  frac_fix;
  logic               align_err;
  logic [7:0]         exp_w;

  frac_align u_frac_align (
    .frac_in  (frac_in),
    .frac_fix (frac_fix),
    .err      (align_err)
  );

  // Leading one sits at bit ACC_W-1 after s shifts; unshifted it weighs 2^7.
  assign exp_w = 8'(BIAS + 7) - 8'(s_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    s_d     = s_q;
    fp_d    = fp_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d                = '0;
          acc_d[ACC_W-1 -: 32] = {int_in, frac_fix};
          s_d                  = '0;
          err_d                = align_err;
          state_d              = NORM;
        end
      end
      NORM: begin
        if (acc_q == '0) begin
          fp_d    = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (acc_q[ACC_W-1]) begin
          fp_d    = {1'b0, exp_w, acc_q[ACC_W-2 -: 23]};
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          acc_d = acc_q << 1;
          s_d   = s_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      s_q     <= '0;
      fp_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      fp_q    <= fp_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign fp_out = fp_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);
  assign err    = err_q;

endmodule
